// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider (DIV/DIVU), one quotient bit per clock.
// Optional macro DIV_EARLY_OUT_EN: finish immediately when |dividend| < |divisor|.
module div_iter #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               annul_i,
   input  logic               start_i,
   input  logic               signed_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o
);

   localparam logic [1:0] S_IDLE    = 2'b00;
   localparam logic [1:0] S_DIVZERO = 2'b01;
   localparam logic [1:0] S_ON      = 2'b10;
   localparam logic [1:0] S_END     = 2'b11;

   logic [1:0]         state;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   dvs;
   logic               q_neg;
   logic               r_neg;
   logic [2*WIDTH-1:0] result;
   logic               ready;

   logic [WIDTH-1:0]   mag1;
   logic [WIDTH-1:0]   mag2;
   logic               early;
   logic [WIDTH:0]     shifted;
   logic [WIDTH+1:0]   diff;
   logic               borrow;
   logic [WIDTH-1:0]   rem_nx;
   logic [WIDTH-1:0]   quo_nx;
   logic [WIDTH-1:0]   q_fin;
   logic [WIDTH-1:0]   r_fin;
   logic               last;

   // 0x80000000 negates to itself, which is already its correct unsigned magnitude
   assign mag1 = (signed_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
   assign mag2 = (signed_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

`ifdef DIV_EARLY_OUT_EN
   assign early = (mag1 < mag2);
`else
   assign early = 1'b0;
`endif

   // The dividend occupies quo and is shifted into rem one bit per step
   assign shifted = {rem, quo[WIDTH-1]};
   assign diff    = {1'b0, shifted} - {2'b00, dvs};
   assign borrow  = diff[WIDTH+1];
   assign rem_nx  = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
   assign quo_nx  = {quo[WIDTH-2:0], ~borrow};
   assign q_fin   = q_neg ? -quo_nx : quo_nx;
   assign r_fin   = r_neg ? -rem_nx : rem_nx;
   assign last    = (cnt == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         cnt    <= '0;
         rem    <= '0;
         quo    <= '0;
         dvs    <= '0;
         q_neg  <= 1'b0;
         r_neg  <= 1'b0;
         result <= '0;
         ready  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               ready  <= 1'b0;
               result <= '0;
               if (start_i && !annul_i) begin
                  if (opdata2_i == '0) begin
                     state <= S_DIVZERO;
                  end else if (early) begin
                     state  <= S_END;
                     result <= {opdata1_i, {WIDTH{1'b0}}};
                     ready  <= 1'b1;
                  end else begin
                     state <= S_ON;
                     rem   <= '0;
                     quo   <= mag1;
                     dvs   <= mag2;
                     q_neg <= signed_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                     r_neg <= signed_i && opdata1_i[WIDTH-1];
                     cnt   <= '0;
                  end
               end
            end
            S_DIVZERO: begin
               if (annul_i) begin
                  state <= S_IDLE;
               end else begin
                  state  <= S_END;
                  result <= '0;
                  ready  <= 1'b1;
               end
            end
            S_ON: begin
               if (annul_i) begin
                  state <= S_IDLE;
               end else begin
                  rem <= rem_nx;
                  quo <= quo_nx;
                  cnt <= cnt + CNT_W'(1);
                  if (last) begin
                     result <= {r_fin, q_fin};
                     ready  <= 1'b1;
                     state  <= S_END;
                  end
               end
            end
            S_END: begin
               if (!start_i || annul_i) begin
                  state <= S_IDLE;
                  ready <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign ready_o  = ready;
   assign result_o = ready ? result : '0;

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: vector table plus annul/reset/handshake sequences.
// Honours DIV_EARLY_OUT_EN for expected latencies.
module tb_div_iter;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          annul_i = 1'b0;
   logic          start_i = 1'b0;
   logic          signed_i = 1'b0;
   logic [W-1:0]  opdata1_i = '0;
   logic [W-1:0]  opdata2_i = '0;
   logic [2*W-1:0] result_o;
   logic          ready_o;

   int checks = 0;
   int errors = 0;

   div_iter #(.WIDTH(W), .CNT_W(6)) dut (
      .clk(clk), .rst(rst), .annul_i(annul_i), .start_i(start_i),
      .signed_i(signed_i), .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
      .result_o(result_o), .ready_o(ready_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          sgn;
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic [2*W-1:0] exp;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] mag(input logic sgn, input logic [W-1:0] x);
      return (sgn && x[W-1]) ? (~x + 32'd1) : x;
   endfunction

   function automatic int exp_lat(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
      if (b == '0) return 1;
`ifdef DIV_EARLY_OUT_EN
      if (mag(sgn, a) < mag(sgn, b)) return 0;
`endif
      return W;
   endfunction

   // Called just after a negedge; the next posedge is the acceptance edge
   task automatic start_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
      signed_i  = sgn;
      opdata1_i = a;
      opdata2_i = b;
      start_i   = 1'b1;
   endtask

   // lat = edges after the acceptance edge before ready_o is seen; -1 on timeout
   task automatic wait_ready(input int max, output int lat);
      lat = -1;
      for (int n = 0; n < max; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (ready_o) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic never_ready(input string name, input int n);
      int seen;
      seen = 0;
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (ready_o) seen++;
      end
      check(name, seen, 0);
   endtask

   task automatic run_div(input string name, input logic sgn, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [2*W-1:0] exp);
      int lat;
      start_op(sgn, a, b);
      wait_ready(100, lat);
      check({name, "_lat"}, lat, exp_lat(sgn, a, b));
      if (lat >= 0) begin
         check({name, "_res"}, result_o, exp);
         step(1);
         check({name, "_hold_rdy"}, ready_o, 1);
         check({name, "_hold_res"}, result_o, exp);
      end
      start_i = 1'b0;
      step(1);
      check({name, "_drop_rdy"}, ready_o, 0);
      check({name, "_drop_res"}, result_o, 0);
   endtask

   initial begin : main
      int lat;
      vecs[0]  = '{1'b0, 32'd100,        32'd7,          {32'h00000002, 32'h0000000E}};
      vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD}};
      vecs[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   {32'h00000001, 32'hFFFFFFFD}};
      vecs[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'h00000000, 32'h80000000}};
      vecs[4]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          {32'h00000000, 32'hFFFFFFFF}};
      vecs[5]  = '{1'b0, 32'd5,          32'd0,          64'd0};
      vecs[6]  = '{1'b1, 32'h80000000,   32'd0,          64'd0};
      vecs[7]  = '{1'b0, 32'd5,          32'd9,          {32'h00000005, 32'h00000000}};
      vecs[8]  = '{1'b1, 32'hFFFFFFFB,   32'd9,          {32'hFFFFFFFB, 32'h00000000}};
      vecs[9]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   {32'h80000000, 32'h00000000}};
      vecs[10] = '{1'b0, 32'd1000,       32'd3,          {32'h00000001, 32'h0000014D}};
      vecs[11] = '{1'b1, 32'hFFFFFC18,   32'hFFFFFFFD,   {32'hFFFFFFFF, 32'h0000014D}};

      step(2);
      check("reset_rdy", ready_o, 0);
      check("reset_res", result_o, 0);
      rst = 1'b0;
      step(1);

      for (int i = 0; i < 12; i++)
         run_div($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp);

      // annul during iteration 10, then a clean 9/3
      start_op(1'b0, 32'd1000, 32'd3);
      step(11);
      annul_i = 1'b1;
      start_i = 1'b0;
      step(1);
      annul_i = 1'b0;
      never_ready("annul_on_no_ready", 40);
      run_div("after_annul", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3});

      // reset during iteration 5
      start_op(1'b0, 32'd1000, 32'd3);
      step(6);
      rst = 1'b1;
      start_i = 1'b0;
      step(1);
      check("rst_on_rdy", ready_o, 0);
      check("rst_on_res", result_o, 0);
      rst = 1'b0;
      never_ready("rst_on_no_ready", 40);

      // annul together with start in IDLE is rejected
      start_op(1'b0, 32'd9, 32'd3);
      annul_i = 1'b1;
      step(1);
      annul_i = 1'b0;
      start_i = 1'b0;
      never_ready("idle_annul_reject", 40);

      // annul in END leaves even though start_i stays high
      start_op(1'b0, 32'd100, 32'd7);
      wait_ready(100, lat);
      check("end_annul_lat", lat, W);
      annul_i = 1'b1;
      step(1);
      check("end_annul_rdy", ready_o, 0);
      check("end_annul_res", result_o, 0);
      annul_i = 1'b0;
      start_i = 1'b0;
      step(1);

      // reset in END with start_i held
      start_op(1'b1, 32'hFFFFFFF9, 32'd2);
      wait_ready(100, lat);
      check("end_rst_lat", lat, W);
      rst = 1'b1;
      step(1);
      check("end_rst_rdy", ready_o, 0);
      check("end_rst_res", result_o, 0);
      rst = 1'b0;
      start_i = 1'b0;
      step(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
